// File: rtl/sid_env_gen.sv
// rtl/sid_env_gen.sv - per-voice SID ADSR envelope generator, stepped on the phi2 tick enable.
// Define ADSR_DELAY_BUG_EN to keep the equality-only rate counter reset (SID ADSR delay bug).
module sid_env_gen #(
  parameter int RATE_W = 15
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       iClkEn,
  input  logic       iGate,
  input  logic [3:0] iAttack,
  input  logic [3:0] iDecay,
  input  logic [3:0] iSustain,
  input  logic [3:0] iRelease,
  output logic [7:0] oEnv,
  output logic [1:0] oState
);

  typedef enum logic [1:0] {
    ST_RELEASE = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_DECAY   = 2'd2
  } state_t;

  // Terminal count (RATE-1) for each rate index.
  function automatic logic [RATE_W-1:0] rate_last(input logic [3:0] idx);
    logic [RATE_W-1:0] v;
    case (idx)
      4'd0:    v = RATE_W'(8);
      4'd1:    v = RATE_W'(31);
      4'd2:    v = RATE_W'(62);
      4'd3:    v = RATE_W'(94);
      4'd4:    v = RATE_W'(148);
      4'd5:    v = RATE_W'(219);
      4'd6:    v = RATE_W'(266);
      4'd7:    v = RATE_W'(312);
      4'd8:    v = RATE_W'(391);
      4'd9:    v = RATE_W'(976);
      4'd10:   v = RATE_W'(1953);
      4'd11:   v = RATE_W'(3125);
      4'd12:   v = RATE_W'(3906);
      4'd13:   v = RATE_W'(11719);
      4'd14:   v = RATE_W'(19531);
      default: v = RATE_W'(31250);
    endcase
    return v;
  endfunction

  function automatic logic [4:0] exp_period(input logic [7:0] lvl);
    logic [4:0] p;
    if (lvl >= 8'd94)      p = 5'd1;
    else if (lvl >= 8'd55) p = 5'd2;
    else if (lvl >= 8'd27) p = 5'd4;
    else if (lvl >= 8'd15) p = 5'd8;
    else if (lvl >= 8'd7)  p = 5'd16;
    else if (lvl >= 8'd1)  p = 5'd30;
    else                   p = 5'd1;
    return p;
  endfunction

  state_t            r_state;
  logic [7:0]        r_env;
  logic [RATE_W-1:0] r_rate_cnt;
  logic [4:0]        r_exp_cnt;
  logic [4:0]        r_exp_period;
  logic              r_gate;

  logic              w_rise;
  logic              w_fall;
  state_t            w_state;
  logic [3:0]        w_idx;
  logic [RATE_W-1:0] w_rate_last;
  logic              w_rate_hit;
  logic              w_rate_ovr;
  logic [RATE_W-1:0] w_rate_cnt_nxt;
  logic [4:0]        w_exp_base;
  logic [4:0]        w_exp_inc;
  logic              w_exp_hit;
  logic              w_dec_ok;
  logic [7:0]        w_env_dec;

  assign w_rise = iGate & ~r_gate;
  assign w_fall = ~iGate & r_gate;

  // Gate edges take effect before the rate step of the same tick.
  always_comb begin
    w_state = r_state;
    if (w_rise)      w_state = ST_ATTACK;
    else if (w_fall) w_state = ST_RELEASE;
  end

  always_comb begin
    w_idx = iRelease;
    case (w_state)
      ST_ATTACK: w_idx = iAttack;
      ST_DECAY:  w_idx = iDecay;
      default:   w_idx = iRelease;
    endcase
  end

  assign w_rate_last = rate_last(w_idx);
  assign w_rate_hit  = (r_rate_cnt == w_rate_last);

`ifdef ADSR_DELAY_BUG_EN
  // A shrunken period is missed until the counter wraps through 2^RATE_W.
  assign w_rate_ovr = 1'b0;
`else
  assign w_rate_ovr = (r_rate_cnt > w_rate_last);
`endif

  assign w_rate_cnt_nxt = (w_rate_hit || w_rate_ovr) ? '0 : r_rate_cnt + 1'b1;

  assign w_exp_base = w_rise ? 5'd0 : r_exp_cnt;
  assign w_exp_inc  = w_exp_base + 5'd1;
  assign w_exp_hit  = (w_exp_inc >= r_exp_period);
  assign w_env_dec  = r_env - 8'd1;

  // Decay stops at the sustain level (and holds if sustain is raised above it).
  always_comb begin
    w_dec_ok = 1'b0;
    if (w_state == ST_DECAY)        w_dec_ok = (r_env > {iSustain, iSustain});
    else if (w_state == ST_RELEASE) w_dec_ok = (r_env != 8'd0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_RELEASE;
      r_env        <= 8'h00;
      r_rate_cnt   <= '0;
      r_exp_cnt    <= 5'd0;
      r_exp_period <= 5'd1;
      r_gate       <= 1'b0;
    end else begin
      r_gate <= iGate;
      if (iClkEn) begin
        r_rate_cnt <= w_rate_cnt_nxt;
        r_state    <= w_state;
        r_exp_cnt  <= w_exp_base;
        if (w_rate_hit) begin
          case (w_state)
            ST_ATTACK: begin
              if (r_env == 8'hFF) begin
                r_state <= ST_DECAY;
              end else begin
                r_env <= r_env + 8'd1;
                if (r_env == 8'hFE) r_state <= ST_DECAY;
              end
            end
            ST_DECAY, ST_RELEASE: begin
              if (w_exp_hit) begin
                r_exp_cnt <= 5'd0;
                if (w_dec_ok) begin
                  r_env        <= w_env_dec;
                  r_exp_period <= exp_period(w_env_dec);
                end
              end else begin
                r_exp_cnt <= w_exp_inc;
              end
            end
            default: r_state <= ST_RELEASE;
          endcase
        end
      end
    end
  end

  assign oEnv   = r_env;
  assign oState = r_state;

endmodule
